// File: rtl/stream_mux_2x1.sv
// Packet-granular round-robin merge of two valid/ready streams into one registered, source-tagged output.
// Latency 1 cycle accept-to-out_valid; both input readies drop while the output beat is stalled.
module stream_mux_2x1 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_sel,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              sel;
  } beat_t;

  state_t           state;
  logic             rr_ptr;
  beat_t            obuf;
  logic             obuf_vld;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  logic  grant0;
  logic  grant1;
  logic  load;
  logic  acc0;
  logic  acc1;
  beat_t in_beat;

  // A locked channel keeps the grant even through bubbles, so the other side cannot interleave.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state)
      LOCK0: grant0 = 1'b1;
      LOCK1: grant1 = 1'b1;
      default: begin
        grant0 = in0_valid && (!in1_valid || !rr_ptr);
        grant1 = in1_valid && (!in0_valid ||  rr_ptr);
      end
    endcase
  end

  assign load      = !obuf_vld || out_ready;
  assign in0_ready = grant0 && load && !rst;
  assign in1_ready = grant1 && load && !rst;
  assign acc0      = in0_valid && in0_ready;
  assign acc1      = in1_valid && in1_ready;

  always_comb begin
    in_beat.data = acc1 ? in1_data : in0_data;
    in_beat.last = acc1 ? in1_last : in0_last;
    in_beat.sel  = acc1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      obuf     <= '0;
      obuf_vld <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else if (acc0 || acc1) begin
      obuf     <= in_beat;
      obuf_vld <= 1'b1;
      if (in_beat.last) begin
        state  <= IDLE;
        rr_ptr <= !in_beat.sel;
        if (in_beat.sel) cnt1_q <= cnt1_q + CNT_W'(1);
        else             cnt0_q <= cnt0_q + CNT_W'(1);
      end else begin
        state <= in_beat.sel ? LOCK1 : LOCK0;
      end
    end else if (out_ready) begin
      obuf_vld <= 1'b0;
    end
  end

  assign out_valid = obuf_vld;
  assign out_data  = obuf.data;
  assign out_last  = obuf.last;
  assign out_sel   = obuf.sel;
  assign pkt_cnt0  = cnt0_q;
  assign pkt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_stream_mux_2x1.sv
// Randomized and directed bench for stream_mux_2x1 against a packet-level scoreboard.
module tb_stream_mux_2x1;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in0_valid, in0_ready, in0_last;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_ready, in1_last;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_ready, out_last, out_sel;
  logic [DW-1:0] out_data;
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;

  always #5 clk = ~clk;

  stream_mux_2x1 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_last(in0_last),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_last(in1_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_sel(out_sel), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] gap;
  } src_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       sel;
  } obeat_t;

  src_t   q0[$];
  src_t   q1[$];
  obeat_t exp_q[$];
  logic [7:0] log_d[$];
  logic       log_s[$];
  logic [7:0] exp_d[$];
  logic       exp_s[$];

  int     n_vec = 0;
  int     n_err = 0;
  int     owner = -1;
  int     last_src = 1;
  int     cnt0 = 0;
  int     cnt1 = 0;
  int     p_valid = 100;
  logic   acc0 = 1'b0;
  logic   acc1 = 1'b0;
  logic   prev_stall = 1'b0;
  logic   rst_q = 1'b1;
  obeat_t prev_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input int ch, input logic [7:0] d, input logic l);
    obeat_t b;
    b.data = d;
    b.last = l;
    b.sel  = (ch == 1);
    exp_q.push_back(b);
    if (l) begin
      if (ch == 0) cnt0 = (cnt0 + 1) % (1 << CW);
      else         cnt1 = (cnt1 + 1) % (1 << CW);
      owner    = -1;
      last_src = ch;
    end else begin
      owner = ch;
    end
  endtask

  // Sources hold a beat stable until it is taken, then honour the next beat's gap.
  task automatic drive();
    src_t t;
    if (acc0) begin void'(q0.pop_front()); in0_valid = 1'b0; end
    if (acc1) begin void'(q1.pop_front()); in1_valid = 1'b0; end
    if (!in0_valid && q0.size() > 0) begin
      t = q0[0];
      if (t.gap == 0) begin
        if ($urandom_range(99) < p_valid) begin
          in0_valid = 1'b1; in0_data = t.data; in0_last = t.last;
        end
      end else begin
        t.gap = t.gap - 4'd1;
        q0[0] = t;
      end
    end
    if (!in1_valid && q1.size() > 0) begin
      t = q1[0];
      if (t.gap == 0) begin
        if ($urandom_range(99) < p_valid) begin
          in1_valid = 1'b1; in1_data = t.data; in1_last = t.last;
        end
      end else begin
        t.gap = t.gap - 4'd1;
        q1[0] = t;
      end
    end
  endtask

  task automatic tick();
    logic   ld, g0, g1, stall;
    obeat_t o;
    drive();
    #1;
    o.data = out_data;
    o.last = out_last;
    o.sel  = out_sel;
    if (rst) begin
      check_eq("rst_ready0", in0_ready, 0);
      check_eq("rst_ready1", in1_ready, 0);
      if (rst_q) begin
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_sel", out_sel, 0);
        check_eq("rst_pkt_cnt0", pkt_cnt0, 0);
        check_eq("rst_pkt_cnt1", pkt_cnt1, 0);
      end
      exp_q.delete();
      owner = -1; last_src = 1; cnt0 = 0; cnt1 = 0;
      prev_stall = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    end else begin
      ld = (exp_q.size() == 0) || out_ready;
      if (owner == 0)      begin g0 = 1'b1; g1 = 1'b0; end
      else if (owner == 1) begin g0 = 1'b0; g1 = 1'b1; end
      else begin
        g0 = in0_valid && (!in1_valid || last_src == 1);
        g1 = in1_valid && (!in0_valid || last_src == 0);
      end
      check_eq("in0_ready", in0_ready, g0 && ld);
      check_eq("in1_ready", in1_ready, g1 && ld);
      check_eq("out_valid", out_valid, exp_q.size() != 0);
      check_eq("pkt_cnt0", pkt_cnt0, cnt0);
      check_eq("pkt_cnt1", pkt_cnt1, cnt1);
      if (prev_stall) check_eq("stall_hold", o, prev_out);
      stall = (exp_q.size() != 0) && !out_ready;
      if (exp_q.size() != 0 && out_ready) begin
        check_eq("out_data", out_data, exp_q[0].data);
        check_eq("out_last", out_last, exp_q[0].last);
        check_eq("out_sel", out_sel, exp_q[0].sel);
        log_d.push_back(out_data);
        log_s.push_back(out_sel);
        void'(exp_q.pop_front());
      end
      prev_stall = stall;
      prev_out   = o;
      acc0 = in0_valid && in0_ready;
      acc1 = in1_valid && in1_ready;
      if (acc0) model_accept(0, in0_data, in0_last);
      if (acc1) model_accept(1, in1_data, in1_last);
    end
    rst_q = rst;
    @(negedge clk);
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    in0_valid = 1'b0; in1_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int max);
    int n = 0;
    out_ready = 1'b1;
    p_valid = 100;
    while ((q0.size() != 0 || q1.size() != 0 || in0_valid || in1_valid || exp_q.size() != 0) && n < max) begin
      tick();
      n++;
    end
    check_eq("drain_done", q0.size() + q1.size() + exp_q.size(), 0);
  endtask

  task automatic check_log(input string tag);
    check_eq({tag, "_len"}, log_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < log_d.size(); i++) begin
      check_eq({tag, "_data"}, log_d[i], exp_d[i]);
      check_eq({tag, "_sel"}, log_s[i], exp_s[i]);
    end
    log_d.delete(); log_s.delete(); exp_d.delete(); exp_s.delete();
  endtask

  task automatic push_exp(input logic [7:0] d, input logic s);
    exp_d.push_back(d);
    exp_s.push_back(s);
  endtask

  task automatic push_rand_pkt(input int ch);
    src_t b;
    int len = $urandom_range(4, 1);
    for (int i = 0; i < len; i++) begin
      b.data = 8'($urandom);
      b.last = (i == len - 1);
      b.gap  = 4'($urandom_range(2));
      if (ch == 0) q0.push_back(b);
      else         q1.push_back(b);
    end
  endtask

  initial begin
    logic [CW-1:0] last_c;
    logic [CW-1:0] cseq[$];
    int            n;

    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    // Reset held with ch0 already presenting its first beat.
    q0.push_back('{data: 8'hA0, last: 1'b0, gap: 4'd0});
    q0.push_back('{data: 8'hA1, last: 1'b0, gap: 4'd0});
    q0.push_back('{data: 8'hA2, last: 1'b1, gap: 4'd0});
    in0_valid = 1'b1; in0_data = 8'hA0; in0_last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    drain(50);
    push_exp(8'hA0, 0); push_exp(8'hA1, 0); push_exp(8'hA2, 0);
    check_log("single_src");
    check_eq("single_src_cnt0", pkt_cnt0, 1);

    // Contention: two-beat packets on both sides.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q0.push_back('{data: 8'h10, last: 1'b0, gap: 4'd0});
      q0.push_back('{data: 8'h11, last: 1'b1, gap: 4'd0});
      q1.push_back('{data: 8'h20, last: 1'b0, gap: 4'd0});
      q1.push_back('{data: 8'h21, last: 1'b1, gap: 4'd0});
      push_exp(8'h10, 0); push_exp(8'h11, 0); push_exp(8'h20, 1); push_exp(8'h21, 1);
    end
    drain(60);
    check_log("contention");

    // Lock hold: ch0 bubbles mid-packet while ch1 waits.
    q0.push_back('{data: 8'hB0, last: 1'b0, gap: 4'd0});
    q0.push_back('{data: 8'hB1, last: 1'b1, gap: 4'd2});
    q1.push_back('{data: 8'hC0, last: 1'b1, gap: 4'd1});
    drain(40);
    push_exp(8'hB0, 0); push_exp(8'hB1, 0); push_exp(8'hC0, 1);
    check_log("lock_hold");

    // Backpressure on a held beat.
    q0.push_back('{data: 8'h55, last: 1'b1, gap: 4'd0});
    q0.push_back('{data: 8'h56, last: 1'b1, gap: 4'd0});
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_data", out_data, 8'h55);
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_ready0", in0_ready, 0);
      check_eq("bp_ready1", in1_ready, 0);
      tick();
    end
    drain(40);
    push_exp(8'h55, 0); push_exp(8'h56, 0);
    check_log("backpressure");

    // Counter wrap with 2-bit counters.
    do_reset();
    for (int i = 0; i < 5; i++)
      q1.push_back('{data: 8'($urandom), last: 1'b1, gap: 4'd0});
    last_c = '0;
    n = 0;
    while ((q1.size() != 0 || in1_valid || exp_q.size() != 0) && n < 40) begin
      tick();
      if (pkt_cnt1 !== last_c) begin
        cseq.push_back(pkt_cnt1);
        last_c = pkt_cnt1;
      end
      n++;
    end
    check_eq("wrap_len", cseq.size(), 5);
    if (cseq.size() == 5) begin
      check_eq("wrap_0", cseq[0], 1);
      check_eq("wrap_1", cseq[1], 2);
      check_eq("wrap_2", cseq[2], 3);
      check_eq("wrap_3", cseq[3], 0);
      check_eq("wrap_4", cseq[4], 1);
    end
    log_d.delete(); log_s.delete();

    // Randomized traffic with gaps, backpressure and one reset mid-stream.
    p_valid = 60;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (q0.size() < 4) push_rand_pkt(0);
      if (q1.size() < 4) push_rand_pkt(1);
      out_ready = ($urandom_range(99) < 70);
      if (cyc == 2000) do_reset();
      tick();
    end
    drain(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
